// File: rtl/tmds_pkg.sv
// Shared TMDS constants: symbol/data/disparity widths, control tokens and guard-band codes.
package tmds_pkg;
    localparam int SYM_W  = 10;
    localparam int DATA_W = 8;
    localparam int DISP_W = 5;

    // Tokens written MSB first; bit 0 leaves the serializer first.
    localparam logic [SYM_W-1:0] CTRL_00  = 10'b1101010100;
    localparam logic [SYM_W-1:0] CTRL_01  = 10'b0010101011;
    localparam logic [SYM_W-1:0] CTRL_10  = 10'b0101010100;
    localparam logic [SYM_W-1:0] CTRL_11  = 10'b1010101011;
    localparam logic [SYM_W-1:0] GUARD_BR = 10'b1011001100;
    localparam logic [SYM_W-1:0] GUARD_G  = 10'b0100110011;

    function automatic logic [SYM_W-1:0] ctrl_token(input logic [1:0] c);
        logic [SYM_W-1:0] tok;
        case (c)
            2'b00:   tok = CTRL_00;
            2'b01:   tok = CTRL_01;
            2'b10:   tok = CTRL_10;
            default: tok = CTRL_11;
        endcase
        return tok;
    endfunction

    function automatic logic [SYM_W-1:0] guard_code(input int channel);
        return (channel == 1) ? GUARD_G : GUARD_BR;
    endfunction
endpackage

// File: rtl/tmds_popcount8.sv
// Combinational count of set bits in an 8-bit word.
module tmds_popcount8 (
    input  logic [7:0] data_i,
    output logic [3:0] count_o
);
    always_comb begin
        count_o = '0;
        for (int i = 0; i < 8; i++) begin
            count_o = count_o + {3'b000, data_i[i]};
        end
    end
endmodule

// File: rtl/tmds_channel_encoder.sv
// One TMDS lane: stage 1 builds the transition-minimised word, stage 2 balances DC
// and substitutes control/guard symbols. Two-cycle latency for every symbol type.
module tmds_channel_encoder
    import tmds_pkg::*;
#(
    parameter int C_channel = 0
) (
    input  logic              clk_pixel,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_c,
    input  logic              in_blank,
    input  logic              in_guard,
    output logic [SYM_W-1:0]  out_tmds
);
    localparam logic [SYM_W-1:0] GUARD_SYM = guard_code(C_channel);

    logic [3:0]        n1_in;
    logic              use_xnor;
    logic [8:0]        qm_d, qm_q;
    logic [3:0]        ones_d, ones_q, zeros_d, zeros_q;
    logic [1:0]        c_q;
    logic              blank_q, guard_q;
    logic [SYM_W-1:0]  sym_d, sym_q;
    logic [DISP_W-1:0] cnt_d, cnt_q;
    logic [DISP_W-1:0] ones5, zeros5, qm8_x2, nqm8_x2;

    tmds_popcount8 u_pop_in (.data_i(in_data),   .count_o(n1_in));
    tmds_popcount8 u_pop_qm (.data_i(qm_d[7:0]), .count_o(ones_d));

    always_comb begin
        use_xnor = (n1_in > 4'd4) || (n1_in == 4'd4 && !in_data[0]);
        qm_d     = '0;
        qm_d[0]  = in_data[0];
        for (int i = 1; i < 8; i++) begin
            qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ in_data[i]) : (qm_d[i-1] ^ in_data[i]);
        end
        qm_d[8] = ~use_xnor;
        zeros_d = 4'd8 - ones_d;
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            qm_q    <= '0;
            ones_q  <= '0;
            zeros_q <= '0;
            c_q     <= 2'b00;
            blank_q <= 1'b1;
            guard_q <= 1'b0;
        end else begin
            qm_q    <= qm_d;
            ones_q  <= ones_d;
            zeros_q <= zeros_d;
            c_q     <= in_c;
            blank_q <= in_blank;
            guard_q <= in_guard;
        end
    end

    // cnt is two's complement; 5-bit wrapping sums are exact because every
    // reachable result lies in -8..+8 even if an intermediate term does not.
    assign ones5   = {1'b0, ones_q};
    assign zeros5  = {1'b0, zeros_q};
    assign qm8_x2  = {3'b000, qm_q[8], 1'b0};
    assign nqm8_x2 = {3'b000, ~qm_q[8], 1'b0};

    always_comb begin
        sym_d = CTRL_00;
        cnt_d = cnt_q;
        if (blank_q) begin
            cnt_d = '0;
            sym_d = guard_q ? GUARD_SYM : ctrl_token(c_q);
        end else if (cnt_q == '0 || ones_q == zeros_q) begin
            sym_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
            cnt_d = qm_q[8] ? (cnt_q + ones5 - zeros5) : (cnt_q + zeros5 - ones5);
        end else if ((!cnt_q[DISP_W-1] && ones_q > zeros_q) ||
                     (cnt_q[DISP_W-1] && zeros_q > ones_q)) begin
            sym_d = {1'b1, qm_q[8], ~qm_q[7:0]};
            cnt_d = cnt_q + qm8_x2 + zeros5 - ones5;
        end else begin
            sym_d = {1'b0, qm_q[8], qm_q[7:0]};
            cnt_d = cnt_q + ones5 - zeros5 - nqm8_x2;
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            sym_q <= CTRL_00;
            cnt_q <= '0;
        end else begin
            sym_q <= sym_d;
            cnt_q <= cnt_d;
        end
    end

    assign out_tmds = sym_q;
endmodule

// File: tb/tb_tmds_channel_encoder.sv
// Bench for tmds_channel_encoder: lanes 0 and 1 side by side against an integer model,
// a reference decoder, an output running-disparity bound and hand-computed symbols.
module tb_tmds_channel_encoder;
    logic       clk_pixel = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic [1:0] in_c = 2'b00;
    logic       in_blank = 1'b1;
    logic       in_guard = 1'b0;
    logic [9:0] out0, out1;

    localparam logic [9:0] T_C00 = 10'b1101010100;
    localparam logic [9:0] T_C01 = 10'b0010101011;
    localparam logic [9:0] T_C10 = 10'b0101010100;
    localparam logic [9:0] T_C11 = 10'b1010101011;
    localparam logic [9:0] T_GBR = 10'b1011001100;
    localparam logic [9:0] T_GG  = 10'b0100110011;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [9:0] s0;
        logic [9:0] s1;
        logic       lv;
        logic [9:0] l0;
        logic [9:0] l1;
        logic       vid;
        logic [7:0] d;
    } exp_t;
    exp_t exp_q[$];

    logic       lit_v = 1'b0;
    logic [9:0] lit0 = '0, lit1 = '0;
    int mcnt = 0;
    int rd0 = 0, rd1 = 0;

    tmds_channel_encoder #(.C_channel(0)) dut_ch0 (
        .clk_pixel(clk_pixel), .reset(reset), .in_data(in_data), .in_c(in_c),
        .in_blank(in_blank), .in_guard(in_guard), .out_tmds(out0)
    );
    tmds_channel_encoder #(.C_channel(1)) dut_ch1 (
        .clk_pixel(clk_pixel), .reset(reset), .in_data(in_data), .in_c(in_c),
        .in_blank(in_blank), .in_guard(in_guard), .out_tmds(out1)
    );

    // clock / reset
    always #5 clk_pixel = ~clk_pixel;

    // Integer model of video encoding: minimise transitions, then balance DC.
    function automatic logic [9:0] enc_video(input logic [7:0] d, input int cnt_in,
                                             output int cnt_out);
        int n1, ones, zeros;
        logic xn, q8;
        logic [7:0] qm;
        logic [9:0] s;
        n1 = $countones(d);
        xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        q8 = ~xn;
        ones = $countones(qm);
        zeros = 8 - ones;
        cnt_out = cnt_in;
        if (cnt_in == 0 || ones == zeros) begin
            s = {~q8, q8, q8 ? qm : ~qm};
            cnt_out = cnt_in + (q8 ? (ones - zeros) : (zeros - ones));
        end else if ((cnt_in > 0 && ones > zeros) || (cnt_in < 0 && zeros > ones)) begin
            s = {1'b1, q8, ~qm};
            cnt_out = cnt_in + (q8 ? 2 : 0) + zeros - ones;
        end else begin
            s = {1'b0, q8, qm};
            cnt_out = cnt_in + ones - zeros - (q8 ? 0 : 2);
        end
        return s;
    endfunction

    function automatic logic [9:0] ctrl_tok(input logic [1:0] c);
        logic [9:0] t;
        case (c)
            2'b00:   t = T_C00;
            2'b01:   t = T_C01;
            2'b10:   t = T_C10;
            default: t = T_C11;
        endcase
        return t;
    endfunction

    function automatic logic [7:0] dec(input logic [9:0] s);
        logic [7:0] t, d;
        t = s[9] ? ~s[7:0] : s[7:0];
        d[0] = t[0];
        for (int i = 1; i < 8; i++) d[i] = s[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
        return d;
    endfunction

    // Model: one expected entry per sampled input set; front entry is due on the output.
    always @(posedge clk_pixel or posedge reset) begin
        exp_t e;
        int nc;
        if (reset) begin
            exp_q.delete();
            e = '{s0: T_C00, s1: T_C00, lv: 1'b1, l0: T_C00, l1: T_C00, vid: 1'b0, d: 8'h00};
            exp_q.push_back(e);
            mcnt = 0;
        end else begin
            e.lv = lit_v; e.l0 = lit0; e.l1 = lit1; e.d = in_data;
            if (in_blank) begin
                e.vid = 1'b0;
                e.s0 = in_guard ? T_GBR : ctrl_tok(in_c);
                e.s1 = in_guard ? T_GG : ctrl_tok(in_c);
                mcnt = 0;
            end else begin
                e.vid = 1'b1;
                e.s0 = enc_video(in_data, mcnt, nc);
                e.s1 = e.s0;
                mcnt = nc;
            end
            exp_q.push_back(e);
        end
    end

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_disp(input string name, input int rd);
        total++;
        if (rd < -8 || rd > 8) begin
            bad++;
            $display("FAIL %s: running disparity %0d outside -8..8 at %0t", name, rd, $time);
        end
    endtask

    // Scoreboard / compare process
    always @(negedge clk_pixel) begin
        exp_t e;
        if (reset) begin
            check("reset_out_ch0", out0, T_C00);
            check("reset_out_ch1", out1, T_C00);
            rd0 = 0; rd1 = 0;
        end else if (exp_q.size() >= 2) begin
            e = exp_q.pop_front();
            check("model_ch0", out0, e.s0);
            check("model_ch1", out1, e.s1);
            if (e.lv) begin
                check("literal_ch0", out0, e.l0);
                check("literal_ch1", out1, e.l1);
            end
            if (e.vid) begin
                check("decode_ch0", {2'b00, dec(out0)}, {2'b00, e.d});
                check("decode_ch1", {2'b00, dec(out1)}, {2'b00, e.d});
                rd0 += 2 * $countones(out0) - 10;
                rd1 += 2 * $countones(out1) - 10;
                check_disp("disparity_ch0", rd0);
                check_disp("disparity_ch1", rd1);
            end else begin
                rd0 = 0; rd1 = 0;
            end
        end
    end

    // Driver tasks
    task automatic send(input logic [7:0] d, input logic [1:0] c, input logic b,
                        input logic g, input logic lv, input logic [9:0] l0,
                        input logic [9:0] l1);
        @(negedge clk_pixel);
        in_data = d; in_c = c; in_blank = b; in_guard = g;
        lit_v = lv; lit0 = l0; lit1 = l1;
    endtask

    task automatic send_lit(input logic [7:0] d, input logic [1:0] c, input logic b,
                            input logic g, input logic [9:0] l);
        send(d, c, b, g, 1'b1, l, l);
    endtask

    initial begin
        repeat (3) @(negedge clk_pixel);
        reset = 1'b0;
        repeat (3) send_lit(8'h00, 2'b00, 1'b1, 1'b0, T_C00);

        send_lit(8'h00, 2'b01, 1'b1, 1'b0, T_C01);
        send_lit(8'h00, 2'b11, 1'b1, 1'b0, T_C11);
        send_lit(8'h00, 2'b10, 1'b1, 1'b0, T_C10);

        send_lit(8'h00, 2'b00, 1'b1, 1'b0, T_C00);
        send_lit(8'h00, 2'b00, 1'b0, 1'b0, 10'h100);
        send_lit(8'h00, 2'b00, 1'b0, 1'b0, 10'h3FF);

        send_lit(8'h00, 2'b00, 1'b1, 1'b0, T_C00);
        send_lit(8'h00, 2'b00, 1'b0, 1'b0, 10'h100);
        send_lit(8'h00, 2'b00, 1'b1, 1'b0, T_C00);
        send_lit(8'h00, 2'b00, 1'b0, 1'b0, 10'h100);

        send(8'h00, 2'b00, 1'b1, 1'b1, 1'b1, T_GBR, T_GG);
        send_lit(8'h00, 2'b00, 1'b0, 1'b1, 10'h100);
        send_lit(8'h00, 2'b00, 1'b1, 1'b0, T_C00);
        send_lit(8'hFF, 2'b00, 1'b0, 1'b0, 10'h200);

        for (int i = 0; i < 6; i++) send(8'(i * 37 + 5), 2'b00, 1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clk_pixel);
        #3 reset = 1'b1;
        #1;
        check("async_reset_ch0", out0, T_C00);
        check("async_reset_ch1", out1, T_C00);
        repeat (2) @(negedge clk_pixel);
        reset = 1'b0;
        in_data = 8'h00; in_c = 2'b00; in_blank = 1'b1; in_guard = 1'b0;
        lit_v = 1'b1; lit0 = T_C00; lit1 = T_C00;
        send_lit(8'h00, 2'b00, 1'b1, 1'b0, T_C00);

        for (int i = 0; i < 3000; i++) begin
            send(8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 1'b0, '0, '0);
        end
        repeat (4) send(8'h00, 2'b00, 1'b1, 1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge clk_pixel);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
